// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
//   sal_t     : tagged value {tag, rdy, data} used on the ROB front, on the
//               broadcast bus and for reservation-station operands.
//   regstat_t : per-architectural-register status {busy, tag}.
package rv32i_types;

  localparam int WIDTH     = 32;
  localparam int NUM_REGS  = 32;
  localparam int TAG_WIDTH = 4;
  localparam int ROB_SIZE  = 8;

  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);

  // Tags at or above this value have no broadcast bus slot.
  localparam logic [TAG_WIDTH-1:0] ROB_SIZE_TAG = TAG_WIDTH'(ROB_SIZE);

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 rdy;
    logic [WIDTH-1:0]     data;
  } sal_t;

  typedef struct packed {
    logic                 busy;
    logic [TAG_WIDTH-1:0] tag;
  } regstat_t;

endpackage

// File: rtl/regfile_operand_lookup.sv
// Combinational operand resolution for one source register.
// Ports:
//   rs          source architectural register
//   reg_val     committed register value for rs
//   stat        busy/tag status for rs
//   commit      ROB is committing a register-writing instr this cycle
//   commit_rd   register written by the committing instr
//   rdest_tag   ROB-front tag
//   rdest_data  ROB-front result
//   bus         completed results, indexed by ROB tag
//   operand     {tag, rdy, data}; rdy=0 means wait on tag, data is don't-care
module regfile_operand_lookup
  import rv32i_types::*;
(
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [WIDTH-1:0]     reg_val,
  input  regstat_t             stat,
  input  logic                 commit,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [TAG_WIDTH-1:0] rdest_tag,
  input  logic [WIDTH-1:0]     rdest_data,
  input  sal_t                 bus [ROB_SIZE],
  output sal_t                 operand
);

  sal_t bus_entry;
  logic bus_hit;
  logic commit_hit;

  // NOTE: every variable gets a value before any branch, so no latch can
  // be inferred when a path leaves it unassigned.
  always_comb begin
    bus_entry  = bus[stat.tag[ROB_IDX_W-1:0]];
    bus_hit    = (stat.tag < ROB_SIZE_TAG) && bus_entry.rdy
                 && (bus_entry.tag == stat.tag);
    // The committing result only satisfies the newest producer; an older
    // producer committing leaves the operand still waiting.
    commit_hit = commit && (commit_rd == rs) && (rdest_tag == stat.tag);

    operand = '0;
    if (rs == '0 || !stat.busy) begin
      operand.rdy  = 1'b1;
      operand.data = reg_val;
    end else if (commit_hit) begin
      operand.tag  = stat.tag;
      operand.rdy  = 1'b1;
      operand.data = rdest_data;
    end else if (bus_hit) begin
      operand.tag  = stat.tag;
      operand.rdy  = 1'b1;
      operand.data = bus_entry.data;
    end else begin
      operand.tag  = stat.tag;
    end
  end

endmodule

// File: rtl/tag_regfile.sv
// Architectural register file with register status table (busy + ROB tag).
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   reg_ld_instr/rd/rd_tag   dispatch marks rd busy with its ROB tag
//   commit/commit_rd/rdest   ROB front writes its result back
//   flush              mispredict: all busy bits clear, dispatch ignored
//   rob_broadcast_bus  completed results indexed by tag (operand bypass)
//   rs1/rs2            dispatching instr sources
//   rs1_out/rs2_out    tagged operands, combinational
module tag_regfile
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_ld_instr,
  input  logic [4:0]           rd,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  input  logic                 commit,
  input  logic [4:0]           commit_rd,
  input  sal_t                 rdest,
  input  logic                 flush,
  input  sal_t                 rob_broadcast_bus [ROB_SIZE],
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output sal_t                 rs1_out,
  output sal_t                 rs2_out
);

  logic [WIDTH-1:0] reg_q  [NUM_REGS];
  logic [WIDTH-1:0] reg_d  [NUM_REGS];
  regstat_t         stat_q [NUM_REGS];
  regstat_t         stat_d [NUM_REGS];

  // A commit is only issued for a completed entry, so the ROB-front rdy
  // bit carries no extra information here.
  logic unused_rdest_rdy;
  assign unused_rdest_rdy = rdest.rdy;

  always_comb begin
    reg_d  = reg_q;
    stat_d = stat_q;

    if (commit && commit_rd != '0) begin
      reg_d[commit_rd] = rdest.data;
      // A newer dispatch to the same register keeps it busy.
      if (stat_q[commit_rd].tag == rdest.tag) begin
        stat_d[commit_rd].busy = 1'b0;
      end
    end

    // Dispatch is applied after commit so a same-cycle dispatch to the
    // committing register wins the busy/tag update.
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        stat_d[i].busy = 1'b0;
      end
    end else if (reg_ld_instr && rd != '0) begin
      stat_d[rd].busy = 1'b1;
      stat_d[rd].tag  = rd_tag;
    end
  end

  // NOTE: the whole register array is reset, since software-visible reset
  // state is all-zero registers; sequential state uses non-blocking
  // assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i]  <= '0;
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i]  <= reg_d[i];
        stat_q[i] <= stat_d[i];
      end
    end
  end

  // Reads use current (pre-dispatch) state, so an instr whose rs equals its
  // own rd sees the previous producer.
  regfile_operand_lookup u_rs1_lookup (
    .rs         (rs1),
    .reg_val    (reg_q[rs1]),
    .stat       (stat_q[rs1]),
    .commit     (commit),
    .commit_rd  (commit_rd),
    .rdest_tag  (rdest.tag),
    .rdest_data (rdest.data),
    .bus        (rob_broadcast_bus),
    .operand    (rs1_out)
  );

  regfile_operand_lookup u_rs2_lookup (
    .rs         (rs2),
    .reg_val    (reg_q[rs2]),
    .stat       (stat_q[rs2]),
    .commit     (commit),
    .commit_rd  (commit_rd),
    .rdest_tag  (rdest.tag),
    .rdest_data (rdest.data),
    .bus        (rob_broadcast_bus),
    .operand    (rs2_out)
  );

endmodule
